// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    // Bus owner of the current transaction
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Access width codes as driven on Bus_Width
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    // Saturating increment of the D-grant streak counter
    function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] max_v);
        logic [3:0] res;
        if (cur >= max_v) begin
            res = max_v;
        end else begin
            res = cur + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the arbiter: data side has priority, fetch is
// protected from starvation by a bounded streak of consecutive D grants.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic If_Req,
    input  logic Mem_DcacheEN,
    input  logic If_Valid,
    input  logic D_Valid,
    input  logic idle_i,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       cand_i_s;
    logic       cand_d_s;

    // A side competing in the cycle it receives its response is never re-granted
    assign cand_i_s = If_Req & ~If_Valid;
    assign cand_d_s = Mem_DcacheEN & ~D_Valid;

    // Grant selection, only meaningful while the bus FSM is idle
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (idle_i) begin
            if (cand_i_s && cand_d_s) begin
                if (streak_q == STREAK_MAX) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (cand_d_s) begin
                grant_d = 1'b1;
            end else if (cand_i_s) begin
                grant_i = 1'b1;
            end else begin
                grant_i = 1'b0;
                grant_d = 1'b0;
            end
        end else begin
            grant_i = 1'b0;
            grant_d = 1'b0;
        end
    end

    // Next streak value: counts D grants that bypassed a waiting fetch
    always_comb begin
        streak_d = streak_q;
        if (!If_Req) begin
            streak_d = 4'd0;
        end else if (grant_i) begin
            streak_d = 4'd0;
        end else if (grant_d) begin
            streak_d = streak_inc(streak_q, STREAK_MAX);
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the Mem
// stage. One outstanding transaction; fetches can be cancelled on redirect.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  If_Req,
    input  logic [ADDR_WIDTH-1:0] If_Addr,
    input  logic                  If_Flush,
    output logic [DATA_WIDTH-1:0] If_Instr,
    output logic                  If_Valid,
    output logic                  Icache_StallReq,
    input  logic                  Mem_DcacheEN,
    input  logic                  Mem_DcacheRd,
    input  logic [1:0]            Mem_DcacheWidth,
    input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
    input  logic [DATA_WIDTH-1:0] EXMem_Rs2Data,
    output logic [DATA_WIDTH-1:0] D_RdData,
    output logic                  D_Valid,
    output logic                  Dcache_StallReq,
    output logic                  Bus_Req,
    output logic                  Bus_We,
    output logic [ADDR_WIDTH-1:0] Bus_Addr,
    output logic [1:0]            Bus_Width,
    output logic [DATA_WIDTH-1:0] Bus_WrData,
    input  logic                  Bus_Gnt,
    input  logic                  Bus_RValid,
    input  logic [DATA_WIDTH-1:0] Bus_RData
);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  drop_q, drop_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [1:0]            bus_width_q, bus_width_d;
    logic [DATA_WIDTH-1:0] bus_wrdata_q, bus_wrdata_d;
    logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  resp_i_q, resp_i_d;
    logic                  resp_d_q, resp_d_d;
    logic                  idle_s;
    logic                  grant_i_s;
    logic                  grant_d_s;
    logic                  flush_hit_s;

    assign idle_s      = (state_q == ST_IDLE);
    assign flush_hit_s = (owner_q == OWN_I) & If_Flush;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_pick (
        .clk          (clk),
        .rst_n        (rst_n),
        .If_Req       (If_Req),
        .Mem_DcacheEN (Mem_DcacheEN),
        .If_Valid     (If_Valid),
        .D_Valid      (D_Valid),
        .idle_i       (idle_s),
        .grant_i      (grant_i_s),
        .grant_d      (grant_d_s)
    );

    // Next-state, capture and flush/drop logic of the transaction FSM
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_width_d  = bus_width_q;
        bus_wrdata_d = bus_wrdata_q;
        if_instr_d   = if_instr_q;
        d_rdata_d    = d_rdata_q;
        resp_i_d     = 1'b0;
        resp_d_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_d      = ST_ADDR;
                    owner_d      = OWN_D;
                    bus_req_d    = 1'b1;
                    bus_we_d     = ~Mem_DcacheRd;
                    bus_addr_d   = Mem_DcacheAddr;
                    bus_width_d  = Mem_DcacheWidth;
                    bus_wrdata_d = EXMem_Rs2Data;
                end else if (grant_i_s) begin
                    state_d      = ST_ADDR;
                    owner_d      = OWN_I;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = If_Addr;
                    bus_width_d  = W_WORD;
                    bus_wrdata_d = {DATA_WIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (flush_hit_s) begin
                    // Already accepted: let the bus finish but discard the result
                    bus_req_d = 1'b0;
                    if (Bus_Gnt) begin
                        state_d = ST_DATA;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (Bus_Gnt) begin
                    state_d   = ST_DATA;
                    bus_req_d = 1'b0;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (Bus_RValid) begin
                    if (drop_q || flush_hit_s) begin
                        state_d = ST_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = ST_RESP;
                        if (owner_q == OWN_I) begin
                            if_instr_d = Bus_RData;
                            resp_i_d   = 1'b1;
                        end else begin
                            d_rdata_d = Bus_RData;
                            resp_d_d  = 1'b1;
                        end
                    end
                end else if (flush_hit_s) begin
                    drop_d = 1'b1;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                drop_d    = 1'b0;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State, capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            drop_q       <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= {ADDR_WIDTH{1'b0}};
            bus_width_q  <= W_BYTE;
            bus_wrdata_q <= {DATA_WIDTH{1'b0}};
            if_instr_q   <= {DATA_WIDTH{1'b0}};
            d_rdata_q    <= {DATA_WIDTH{1'b0}};
            resp_i_q     <= 1'b0;
            resp_d_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_width_q  <= bus_width_d;
            bus_wrdata_q <= bus_wrdata_d;
            if_instr_q   <= if_instr_d;
            d_rdata_q    <= d_rdata_d;
            resp_i_q     <= resp_i_d;
            resp_d_q     <= resp_d_d;
        end
    end

    assign Bus_Req         = bus_req_q;
    assign Bus_We          = bus_we_q;
    assign Bus_Addr        = bus_addr_q;
    assign Bus_Width       = bus_width_q;
    assign Bus_WrData      = bus_wrdata_q;
    assign If_Instr        = if_instr_q;
    assign D_RdData        = d_rdata_q;
    // A redirect arriving in the response cycle suppresses the fetch pulse
    assign If_Valid        = resp_i_q & ~If_Flush;
    assign D_Valid         = resp_d_q;
    assign Icache_StallReq = If_Req & ~If_Valid & ~If_Flush;
    assign Dcache_StallReq = Mem_DcacheEN & ~D_Valid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level reference model of the arbiter.
module tb_mem_bus_arbiter;

    localparam int MAXS = 4;

    logic        clk;
    logic        rst_n;
    logic        If_Req;
    logic [31:0] If_Addr;
    logic        If_Flush;
    logic [31:0] If_Instr;
    logic        If_Valid;
    logic        Icache_StallReq;
    logic        Mem_DcacheEN;
    logic        Mem_DcacheRd;
    logic [1:0]  Mem_DcacheWidth;
    logic [31:0] Mem_DcacheAddr;
    logic [31:0] EXMem_Rs2Data;
    logic [31:0] D_RdData;
    logic        D_Valid;
    logic        Dcache_StallReq;
    logic        Bus_Req;
    logic        Bus_We;
    logic [31:0] Bus_Addr;
    logic [1:0]  Bus_Width;
    logic [31:0] Bus_WrData;
    logic        Bus_Gnt;
    logic        Bus_RValid;
    logic [31:0] Bus_RData;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state (random phase)
    bit          m_free, m_req, m_data, m_resp, m_own_d, m_we;
    int          m_wait, m_streak;
    logic [31:0] m_addr, m_wd, m_rdata, last_i, last_d;
    logic [1:0]  m_w;
    bit          i_done, d_done;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .If_Req(If_Req), .If_Addr(If_Addr), .If_Flush(If_Flush),
        .If_Instr(If_Instr), .If_Valid(If_Valid), .Icache_StallReq(Icache_StallReq),
        .Mem_DcacheEN(Mem_DcacheEN), .Mem_DcacheRd(Mem_DcacheRd),
        .Mem_DcacheWidth(Mem_DcacheWidth), .Mem_DcacheAddr(Mem_DcacheAddr),
        .EXMem_Rs2Data(EXMem_Rs2Data), .D_RdData(D_RdData), .D_Valid(D_Valid),
        .Dcache_StallReq(Dcache_StallReq),
        .Bus_Req(Bus_Req), .Bus_We(Bus_We), .Bus_Addr(Bus_Addr), .Bus_Width(Bus_Width),
        .Bus_WrData(Bus_WrData), .Bus_Gnt(Bus_Gnt), .Bus_RValid(Bus_RValid),
        .Bus_RData(Bus_RData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after the negedge of the cycle in which Bus_Req must be high;
    // answers with zero wait states and returns inside the response cycle.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                         input logic own_d, input logic [31:0] rd);
        check({tag, "_req"}, Bus_Req, 1'b1);
        check({tag, "_addr"}, Bus_Addr, exp_addr);
        check({tag, "_we"}, Bus_We, exp_we);
        Bus_Gnt = 1'b1;
        @(negedge clk);
        Bus_Gnt    = 1'b0;
        Bus_RValid = 1'b1;
        Bus_RData  = rd;
        @(negedge clk);
        Bus_RValid = 1'b0;
        #1;
        check({tag, "_ivalid"}, If_Valid, !own_d);
        check({tag, "_dvalid"}, D_Valid, own_d);
        if (own_d) check({tag, "_drdata"}, D_RdData, rd);
        else       check({tag, "_instr"}, If_Instr, rd);
    endtask

    initial begin
        bit          n_free, n_req, n_data, n_resp, sel, sel_d;
        int          n_wait;
        rst_n = 1'b0; If_Req = 1'b0; If_Addr = 32'd0; If_Flush = 1'b0;
        Mem_DcacheEN = 1'b0; Mem_DcacheRd = 1'b0; Mem_DcacheWidth = 2'd0;
        Mem_DcacheAddr = 32'd0; EXMem_Rs2Data = 32'd0;
        Bus_Gnt = 1'b0; Bus_RValid = 1'b0; Bus_RData = 32'd0;

        // ---- reset state
        #2;
        check("rst_busreq", Bus_Req, 1'b0);
        check("rst_ivalid", If_Valid, 1'b0);
        check("rst_dvalid", D_Valid, 1'b0);
        check("rst_instr", If_Instr, 32'd0);
        check("rst_busaddr", Bus_Addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- fetch only, minimum latency
        @(negedge clk);
        If_Req = 1'b1; If_Addr = 32'h100;
        #1 check("f_stall0", Icache_StallReq, 1'b1);
        check("f_busreq0", Bus_Req, 1'b0);
        @(negedge clk);
        check("f_busreq1", Bus_Req, 1'b1);
        check("f_addr1", Bus_Addr, 32'h100);
        check("f_we1", Bus_We, 1'b0);
        check("f_width1", Bus_Width, 2'd2);
        Bus_Gnt = 1'b1;
        #1 check("f_stall1", Icache_StallReq, 1'b1);
        @(negedge clk);
        Bus_Gnt = 1'b0;
        check("f_busreq2", Bus_Req, 1'b0);
        Bus_RValid = 1'b1; Bus_RData = 32'h13;
        #1 check("f_stall2", Icache_StallReq, 1'b1);
        check("f_ivalid2", If_Valid, 1'b0);
        @(negedge clk);
        Bus_RValid = 1'b0;
        #1 check("f_ivalid3", If_Valid, 1'b1);
        check("f_instr3", If_Instr, 32'h13);
        check("f_stall3", Icache_StallReq, 1'b0);
        @(negedge clk);
        If_Req = 1'b0;
        #1 check("f_ivalid4", If_Valid, 1'b0);
        @(negedge clk);
        check("f_busreq5", Bus_Req, 1'b0);

        // ---- both request: D store first, then I after D_Valid
        If_Req = 1'b1; If_Addr = 32'h104;
        Mem_DcacheEN = 1'b1; Mem_DcacheRd = 1'b0; Mem_DcacheWidth = 2'd2;
        Mem_DcacheAddr = 32'h2000; EXMem_Rs2Data = 32'hDEADBEEF;
        @(negedge clk);
        check("b_wrdata", Bus_WrData, 32'hDEADBEEF);
        check("b_width", Bus_Width, 2'd2);
        serve("b_d", 32'h2000, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        Mem_DcacheEN = 1'b0;
        check("b_idle_busreq", Bus_Req, 1'b0);
        @(negedge clk);
        serve("b_i", 32'h104, 1'b0, 1'b0, 32'h0000_0093);
        @(negedge clk);
        If_Req = 1'b0;

        // ---- streak: 4 D grants, then I, then D again
        @(negedge clk);
        If_Req = 1'b1; If_Addr = 32'h400;
        Mem_DcacheEN = 1'b1; Mem_DcacheRd = 1'b1; Mem_DcacheWidth = 2'd2;
        Mem_DcacheAddr = 32'h3000; EXMem_Rs2Data = 32'h0;
        for (int k = 0; k < MAXS; k++) begin
            @(negedge clk);
            serve("s_d", 32'h3000, 1'b0, 1'b1, 32'h100 + k);
            @(negedge clk);
        end
        @(negedge clk);
        serve("s_i", 32'h400, 1'b0, 1'b0, 32'h0000_0AAA);
        @(negedge clk);
        If_Req = 1'b0;
        @(negedge clk);
        serve("s_dres", 32'h3000, 1'b0, 1'b1, 32'h0000_0BBB);
        @(negedge clk);
        Mem_DcacheEN = 1'b0;
        @(negedge clk);
        check("s_quiet", Bus_Req, 1'b0);

        // ---- flush while in DATA, then RValid; new fetch to 0x200
        If_Req = 1'b1; If_Addr = 32'h180;
        @(negedge clk);
        check("fd_addr", Bus_Addr, 32'h180);
        Bus_Gnt = 1'b1;
        @(negedge clk);
        Bus_Gnt = 1'b0; If_Flush = 1'b1; If_Addr = 32'h200;
        #1 check("fd_stall", Icache_StallReq, 1'b0);
        @(negedge clk);
        If_Flush = 1'b0; Bus_RValid = 1'b1; Bus_RData = 32'h99;
        #1 check("fd_ivalid_rv", If_Valid, 1'b0);
        @(negedge clk);
        Bus_RValid = 1'b0;
        #1 check("fd_ivalid_skip", If_Valid, 1'b0);
        check("fd_instr_hold", If_Instr, 32'h0000_0AAA);
        check("fd_busreq_idle", Bus_Req, 1'b0);
        @(negedge clk);
        serve("fd_new", 32'h200, 1'b0, 1'b0, 32'h55);
        @(negedge clk);
        If_Req = 1'b0;

        // ---- flush coincident with RValid
        @(negedge clk);
        If_Req = 1'b1; If_Addr = 32'h280;
        @(negedge clk);
        Bus_Gnt = 1'b1;
        @(negedge clk);
        Bus_Gnt = 1'b0; Bus_RValid = 1'b1; Bus_RData = 32'h77; If_Flush = 1'b1;
        @(negedge clk);
        Bus_RValid = 1'b0; If_Flush = 1'b0; If_Req = 1'b0;
        #1 check("fr_ivalid", If_Valid, 1'b0);
        check("fr_instr", If_Instr, 32'h55);
        @(negedge clk);
        check("fr_ivalid2", If_Valid, 1'b0);
        check("fr_busreq", Bus_Req, 1'b0);

        // ---- flush in ADDR with Gnt low
        If_Req = 1'b1; If_Addr = 32'h240;
        @(negedge clk);
        check("fa_busreq1", Bus_Req, 1'b1);
        If_Flush = 1'b1;
        @(negedge clk);
        If_Flush = 1'b0; If_Req = 1'b0;
        check("fa_busreq2", Bus_Req, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fa_busreq_q", Bus_Req, 1'b0);
            check("fa_ivalid_q", If_Valid, 1'b0);
        end

        // ---- reset asserted in DATA, then a stale RValid
        Mem_DcacheEN = 1'b1; Mem_DcacheRd = 1'b1; Mem_DcacheWidth = 2'd0;
        Mem_DcacheAddr = 32'h500;
        @(negedge clk);
        check("rd_addr", Bus_Addr, 32'h500);
        check("rd_width", Bus_Width, 2'd0);
        Bus_Gnt = 1'b1;
        @(negedge clk);
        Bus_Gnt = 1'b0;
        #2 rst_n = 1'b0; Mem_DcacheEN = 1'b0;
        #1 check("rd_busreq", Bus_Req, 1'b0);
        check("rd_busaddr", Bus_Addr, 32'h0);
        check("rd_instr", If_Instr, 32'h0);
        check("rd_drdata", D_RdData, 32'h0);
        check("rd_dvalid", D_Valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; Bus_RValid = 1'b1; Bus_RData = 32'h66;
        #1 check("rd_dvalid_rv", D_Valid, 1'b0);
        @(negedge clk);
        Bus_RValid = 1'b0;
        #1 check("rd_dvalid_after", D_Valid, 1'b0);
        check("rd_drdata_after", D_RdData, 32'h0);
        check("rd_busreq_after", Bus_Req, 1'b0);

        // ---- randomized traffic against the reference model
        m_free = 1; m_req = 0; m_data = 0; m_resp = 0; m_own_d = 0; m_we = 0;
        m_wait = 0; m_streak = 0; m_addr = 0; m_wd = 0; m_rdata = 0; m_w = 0;
        last_i = 32'h0; last_d = 32'h0; i_done = 0; d_done = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (i_done) If_Req = 1'b0;
            if (d_done) Mem_DcacheEN = 1'b0;
            i_done = 0; d_done = 0;
            if (!If_Req && $urandom_range(0, 2) == 0) begin
                If_Req = 1'b1; If_Addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!Mem_DcacheEN && $urandom_range(0, 2) == 0) begin
                Mem_DcacheEN = 1'b1; Mem_DcacheRd = 1'($urandom_range(0, 1));
                Mem_DcacheWidth = 2'($urandom_range(0, 2));
                Mem_DcacheAddr = $urandom(); EXMem_Rs2Data = $urandom();
            end
            check("r_busreq", Bus_Req, m_req);
            if (m_req) begin
                check("r_addr", Bus_Addr, m_addr);
                check("r_we", Bus_We, m_we);
                check("r_width", Bus_Width, m_w);
                check("r_wrdata", Bus_WrData, m_wd);
            end
            Bus_Gnt    = m_req ? 1'($urandom_range(0, 1)) : 1'b0;
            Bus_RValid = m_data && (m_wait == 1);
            Bus_RData  = $urandom();
            #1;
            check("r_ivalid", If_Valid, m_resp && !m_own_d);
            check("r_dvalid", D_Valid, m_resp && m_own_d);
            check("r_instr", If_Instr, last_i);
            check("r_drdata", D_RdData, last_d);
            check("r_istall", Icache_StallReq, If_Req && !(m_resp && !m_own_d));
            check("r_dstall", Dcache_StallReq, Mem_DcacheEN && !(m_resp && m_own_d));
            // advance the model by one cycle
            n_free = 0; n_req = 0; n_data = 0; n_resp = 0; n_wait = 0;
            if (m_resp) begin
                n_free = 1;
                if (m_own_d) d_done = 1; else i_done = 1;
            end
            if (m_data) begin
                if (m_wait == 1) begin
                    n_resp = 1;
                    if (m_own_d) last_d = Bus_RData; else last_i = Bus_RData;
                end else begin
                    n_data = 1; n_wait = m_wait - 1;
                end
            end
            if (m_req) begin
                if (Bus_Gnt) begin n_data = 1; n_wait = $urandom_range(1, 3); end
                else n_req = 1;
            end
            if (m_free) begin
                sel = 1; sel_d = 0;
                if (If_Req && Mem_DcacheEN) sel_d = (m_streak != MAXS);
                else if (Mem_DcacheEN)      sel_d = 1;
                else if (If_Req)            sel_d = 0;
                else                        sel = 0;
                if (sel) begin
                    n_req = 1; m_own_d = sel_d;
                    if (sel_d) begin
                        m_addr = Mem_DcacheAddr; m_we = !Mem_DcacheRd;
                        m_w = Mem_DcacheWidth; m_wd = EXMem_Rs2Data;
                        if (If_Req && m_streak < MAXS) m_streak++;
                    end else begin
                        m_addr = If_Addr; m_we = 0; m_w = 2'd2; m_wd = 32'h0;
                        m_streak = 0;
                    end
                end else begin
                    n_free = 1;
                end
            end
            if (!If_Req) m_streak = 0;
            m_free = n_free; m_req = n_req; m_data = n_data; m_resp = n_resp; m_wait = n_wait;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
